// File: rtl/uart_tx.sv
// UART transmitter: write-side FIFO feeding an 8N1-style serializer.
// Ports: clk, rst_n, wr_en/wr_data in; full, empty, count, overflow, busy, TxOut out.
module uart_tx #(
  parameter int WIDTH       = 8,
  parameter int PARITY      = 0,
  parameter int STOP        = 1,
  parameter int SAMPLES     = 16,
  parameter int BUF_ADDR_SZ = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  output logic                   full,
  output logic                   empty,
  output logic [BUF_ADDR_SZ:0]   count,
  output logic                   overflow,
  output logic                   busy,
  output logic                   TxOut
);

  localparam int DEPTH = 2 ** BUF_ADDR_SZ;
  localparam int CW    = $clog2(SAMPLES);
  localparam int BW    = $clog2(WIDTH);
  localparam int AW    = BUF_ADDR_SZ;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BW-1:0]    idx_q, idx_d;
  logic             stp_q, stp_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             par_q, par_d;
  logic             tx_q, tx_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             push, pop, load, bit_end;
  logic [WIDTH-1:0] head;

  assign full     = (count_q == (AW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign overflow = ovf_q;
  assign busy     = (state_q != ST_IDLE);
  assign TxOut    = tx_q;

  assign push    = wr_en & ~full;
  assign head    = mem_q[rd_ptr_q];
  assign bit_end = (cnt_q == CW'(SAMPLES - 1));

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
    ovf_d    = wr_en & full;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    idx_d   = idx_q;
    stp_d   = stp_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    load    = 1'b0;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        tx_d  = 1'b1;
        if (!empty) load = 1'b1;
      end
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          cnt_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == BW'(WIDTH - 1)) begin
            stp_d = 1'b0;
            if (PARITY != 0) begin
              state_d = ST_PAR;
              tx_d    = par_q;
            end else begin
              state_d = ST_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            idx_d   = idx_q + BW'(1);
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
      ST_PAR: begin
        if (bit_end) begin
          state_d = ST_STOP;
          cnt_d   = '0;
          stp_d   = 1'b0;
          tx_d    = 1'b1;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (stp_q == 1'(STOP - 1)) begin
            // back-to-back frames: start bit follows the last stop cycle
            if (!empty) begin
              load = 1'b1;
            end else begin
              state_d = ST_IDLE;
              tx_d    = 1'b1;
            end
          end else begin
            stp_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        tx_d    = 1'b1;
      end
    endcase
    if (load) begin
      pop     = 1'b1;
      state_d = ST_START;
      cnt_d   = '0;
      idx_d   = '0;
      stp_d   = 1'b0;
      shift_d = head;
      par_d   = (^head) ^ (PARITY == 2);
      tx_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      stp_q    <= 1'b0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      stp_q    <= stp_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      tx_q     <= tx_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: default, even/odd parity and 2-stop/4-sample builds.
// Frames are checked sample by sample against hand-built bit vectors.
module tb_uart_tx;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic       wr_a, wr_e, wr_o, wr_s;
  logic [7:0] wd_a, wd_e, wd_o, wd_s;
  logic       full_a, full_e, full_o, full_s;
  logic       empty_a, empty_e, empty_o, empty_s;
  logic [4:0] cnt_a, cnt_e, cnt_o, cnt_s;
  logic       ovf_a, ovf_e, ovf_o, ovf_s;
  logic       busy_a, busy_e, busy_o, busy_s;
  logic       tx_a, tx_e, tx_o, tx_s;

  uart_tx dut_a (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_a), .wr_data(wd_a),
    .full(full_a), .empty(empty_a), .count(cnt_a),
    .overflow(ovf_a), .busy(busy_a), .TxOut(tx_a)
  );

  uart_tx #(.PARITY(1)) dut_e (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_e), .wr_data(wd_e),
    .full(full_e), .empty(empty_e), .count(cnt_e),
    .overflow(ovf_e), .busy(busy_e), .TxOut(tx_e)
  );

  uart_tx #(.PARITY(2)) dut_o (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_o), .wr_data(wd_o),
    .full(full_o), .empty(empty_o), .count(cnt_o),
    .overflow(ovf_o), .busy(busy_o), .TxOut(tx_o)
  );

  uart_tx #(.STOP(2), .SAMPLES(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_s), .wr_data(wd_s),
    .full(full_s), .empty(empty_s), .count(cnt_s),
    .overflow(ovf_s), .busy(busy_s), .TxOut(tx_s)
  );

  function automatic logic txo(input int sel);
    case (sel)
      1:       return tx_e;
      2:       return tx_o;
      3:       return tx_s;
      default: return tx_a;
    endcase
  endfunction

  function automatic logic bsy(input int sel);
    case (sel)
      1:       return busy_e;
      2:       return busy_o;
      3:       return busy_s;
      default: return busy_a;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sample k of a frame is the k-th sample after the pop edge.
  task automatic frame_chk(input int sel, input logic [11:0] bits,
                           input int nb, input int sp, input int k0,
                           input string tag);
    for (int k = k0; k < nb * sp; k++) begin
      chk({tag, "_tx"}, 32'(txo(sel)), 32'(bits[k / sp]));
      chk({tag, "_busy"}, 32'(bsy(sel)), 32'd1);
      tick();
    end
  endtask

  initial begin
    logic act;
    rst_n = 1'b0;
    {wr_a, wr_e, wr_o, wr_s} = '0;
    {wd_a, wd_e, wd_o, wd_s} = '0;
    #1;
    repeat (3) tick();
    chk("rst_tx", 32'(tx_a), 32'd1);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_empty", 32'(empty_a), 32'd1);
    chk("rst_full", 32'(full_a), 32'd0);
    chk("rst_count", 32'(cnt_a), 32'd0);
    chk("rst_ovf", 32'(ovf_a), 32'd0);
    rst_n = 1'b1;
    tick();

    // single 0x55 frame, two-edge latency
    wr_a = 1'b1; wd_a = 8'h55;
    tick();
    wr_a = 1'b0;
    chk("s1_count", 32'(cnt_a), 32'd1);
    chk("s1_empty", 32'(empty_a), 32'd0);
    chk("s1_tx_idle", 32'(tx_a), 32'd1);
    chk("s1_busy_idle", 32'(busy_a), 32'd0);
    tick();
    chk("s1_count_pop", 32'(cnt_a), 32'd0);
    frame_chk(0, {1'b1, 8'h55, 1'b0}, 10, 16, 0, "s1");
    chk("s1_end_tx", 32'(tx_a), 32'd1);
    chk("s1_end_busy", 32'(busy_a), 32'd0);
    repeat (5) tick();

    // parity builds, 0x07
    wr_e = 1'b1; wd_e = 8'h07;
    tick();
    wr_e = 1'b0;
    tick();
    frame_chk(1, {1'b1, 1'b1, 8'h07, 1'b0}, 11, 16, 0, "s2e");
    chk("s2e_end_busy", 32'(busy_e), 32'd0);
    wr_o = 1'b1; wd_o = 8'h07;
    tick();
    wr_o = 1'b0;
    tick();
    frame_chk(2, {1'b1, 1'b0, 8'h07, 1'b0}, 11, 16, 0, "s2o");
    chk("s2o_end_busy", 32'(busy_o), 32'd0);

    // back-to-back frames
    wr_a = 1'b1; wd_a = 8'hA5;
    tick();
    wd_a = 8'h3C;
    tick();
    wr_a = 1'b0;
    frame_chk(0, {1'b1, 8'hA5, 1'b0}, 10, 16, 0, "s3a");
    frame_chk(0, {1'b1, 8'h3C, 1'b0}, 10, 16, 0, "s3b");
    chk("s3_empty", 32'(empty_a), 32'd1);
    chk("s3_busy", 32'(busy_a), 32'd0);
    chk("s3_tx", 32'(tx_a), 32'd1);
    repeat (3) tick();

    // fill to full, one dropped write
    wr_a = 1'b1;
    for (int i = 0; i < 18; i++) begin
      wd_a = 8'(8'h30 + i);
      tick();
      chk("s4_count", 32'(cnt_a),
          (i == 0) ? 32'd1 : ((i == 17) ? 32'd16 : 32'(i)));
      chk("s4_full", 32'(full_a), (i >= 16) ? 32'd1 : 32'd0);
      chk("s4_ovf", 32'(ovf_a), (i == 17) ? 32'd1 : 32'd0);
    end
    wr_a = 1'b0;
    tick();
    chk("s4_ovf_clr", 32'(ovf_a), 32'd0);
    frame_chk(0, {1'b1, 8'h30, 1'b0}, 10, 16, 17, "s4f0");
    for (int f = 1; f < 17; f++) begin
      frame_chk(0, {1'b1, 8'(8'h30 + f), 1'b0}, 10, 16, 0, "s4f");
    end
    chk("s4_busy", 32'(busy_a), 32'd0);
    chk("s4_empty", 32'(empty_a), 32'd1);
    repeat (3) tick();

    // reset mid-frame with three words queued
    wr_a = 1'b1; wd_a = 8'h11;
    tick();
    wd_a = 8'h22;
    tick();
    wd_a = 8'h33;
    tick();
    wd_a = 8'h44;
    tick();
    wr_a = 1'b0;
    chk("s5_count", 32'(cnt_a), 32'd3);
    repeat (68) tick();
    chk("s5_tx_bit3", 32'(tx_a), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("s5_rst_tx", 32'(tx_a), 32'd1);
    chk("s5_rst_count", 32'(cnt_a), 32'd0);
    chk("s5_rst_busy", 32'(busy_a), 32'd0);
    chk("s5_rst_empty", 32'(empty_a), 32'd1);
    repeat (2) tick();
    rst_n = 1'b1;
    act = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (tx_a !== 1'b1 || busy_a !== 1'b0) act = 1'b1;
    end
    chk("s5_quiet", 32'(act), 32'd0);
    wr_a = 1'b1; wd_a = 8'h5A;
    tick();
    wr_a = 1'b0;
    chk("s5_lat1_tx", 32'(tx_a), 32'd1);
    tick();
    frame_chk(0, {1'b1, 8'h5A, 1'b0}, 10, 16, 0, "s5f");
    chk("s5_end_busy", 32'(busy_a), 32'd0);

    // two stop bits, four samples per bit
    wr_s = 1'b1; wd_s = 8'hFF;
    tick();
    wr_s = 1'b0;
    tick();
    frame_chk(3, {1'b1, 1'b1, 8'hFF, 1'b0}, 11, 4, 0, "s6");
    chk("s6_end_busy", 32'(busy_s), 32'd0);
    chk("s6_end_tx", 32'(tx_s), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
